// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: valid/ready request port, per-lane write mask,
// fixed read latency of RD_LAT cycles and a zero-fill sweep after every reset.
module sram_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LANE_W     = 4,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [WIDTH-1:0]          req_wdata,
    input  logic [WIDTH/LANE_W-1:0]   req_wmask,
    output logic                      rsp_valid,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic                      rsp_err,
    output logic                      init_done
);

    localparam int unsigned LANES = WIDTH / LANE_W;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    accept;
    logic                    in_range;
    logic [WIDTH-1:0]        rd_word;
    logic [WIDTH-1:0]        mem [DEPTH];

    logic [RD_LAT-1:0]            vld_q;
    logic [RD_LAT-1:0]            err_q;
    logic [RD_LAT-1:0][WIDTH-1:0] data_q;

    assign accept   = req_valid && req_ready;
    assign in_range = {1'b0, req_addr} < DepthExt;

    // Next-state logic: sweep counter saturates at DEPTH-1, then RUN forever.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        init_done = 1'b0;
        unique case (state_q)
            StInit: begin
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            StRun: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_d = StInit;
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage: zero-fill during INIT, masked in-range writes during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == StInit) begin
                mem[cnt_q] <= '0;
            end else if (accept && req_we && in_range) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (req_wmask[k]) begin
                        mem[req_addr][k*LANE_W +: LANE_W] <= req_wdata[k*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    // Read data is forced to zero for writes, idle cycles and out-of-range reads.
    always_comb begin
        rd_word = '0;
        if (accept && !req_we && in_range) begin
            rd_word = mem[req_addr];
        end
    end

    // Response pipeline: stage 0 captures at the accepting edge, later stages delay.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= '0;
            err_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0]  <= accept;
            err_q[0]  <= accept && !in_range;
            data_q[0] <= rd_word;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign rsp_valid = vld_q[RD_LAT-1];
    assign rsp_err   = err_q[RD_LAT-1];
    assign rsp_rdata = data_q[RD_LAT-1];

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised single-port SRAM controller with a valid/ready request port, per-lane write masking, a configurable fixed read latency and a hardware clear sweep after reset. It is the successor to `sram_top` and sits between a requesting master and on-chip storage. The controller owns the storage array and guarantees that memory reads zero after every reset. Every request returns a response, including out-of-range addresses.

## Interface
- `WIDTH`, default 16: data word width in bits; must be a multiple of `LANE_W`.
- `LANE_W`, default 4: bits per write-mask lane; `LANES = WIDTH/LANE_W`.
- `DEPTH`, default 32: number of words; any value ≥ 2, not necessarily a power of two.
- `RD_LAT`, default 1: read latency in cycles, legal range 1–3.
- `ADDR_WIDTH`, default `$clog2(DEPTH)`: derived; must not be overridden.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous reset, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: controller can accept a request.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, `ADDR_WIDTH`: word address.
- `req_wdata`, in, `WIDTH`: write data.
- `req_wmask`, in, `LANES`: lane enables; bit k covers `req_wdata[k*LANE_W +: LANE_W]`.
- `rsp_valid`, out, 1: one-cycle pulse that flags a response.
- `rsp_rdata`, out, `WIDTH`: read data; 0 for write responses.
- `rsp_err`, out, 1: the response is for an out-of-range address (`req_addr >= DEPTH`).
- `init_done`, out, 1: the clear sweep is complete.

## Operation
- The FSM has two states, INIT and RUN. Reset (`rst` = 0 sampled at an edge) forces INIT, sweep counter = 0, and clears the response pipeline.
- **INIT:**
  - On each edge with `rst` = 1, the controller writes all-zero to `mem[cnt]` and increments `cnt`.
  - On the edge where `cnt == DEPTH-1`, the FSM moves to RUN.
  - `req_ready` = 0 and `init_done` = 0 throughout INIT.
- **RUN:** `req_ready` = 1 and `init_done` = 1 continuously. There is no backpressure.
- **Accept:** a request is accepted on an edge where `req_valid && req_ready`. At most one request is accepted per cycle.
- **Write, in range:** only lanes with a mask bit of 1 are updated, at the accepting edge. A mask of all-zero is a legal no-op write.
- **Write response:** every accepted request, read or write, produces exactly one response.
  - For a write, `rsp_rdata` = 0 and `rsp_err` = 0 when in range.
- **Read, in range:** `rsp_rdata` = the word contents after all earlier accepted writes. A read accepted on the edge directly after a write to the same address returns the new data.
- **Out of range:**
  - A write does not modify memory.
  - A read returns `rsp_rdata` = 0.
  - In both cases `rsp_err` = 1.
- **Responses:** they return in request order. The pipeline is `RD_LAT` stages deep, so up to `RD_LAT` responses can be in flight.

## Timing
- **During reset and the cycle after it:**
  - `req_ready` = 0, `init_done` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- **Sweep length:** if `rst` rises before edge E0, then edges E0..E(DEPTH-1) perform the clear. `req_ready` and `init_done` go to 1 in the cycle after E(DEPTH-1). The first request can be accepted at edge E(DEPTH).
- **Response timing:** for a request accepted at edge A, `rsp_valid` is high in exactly the one cycle between edges A+RD_LAT-1 and A+RD_LAT, with `rsp_rdata`/`rsp_err` valid alongside it.
  - RD_LAT = 1 gives a registered output.
  - When no response is due, `rsp_valid` = 0 and `rsp_rdata` holds 0.
- **Throughput:** with `req_valid` held high in RUN, one request is accepted per cycle and `rsp_valid` pulses every cycle.
- **Reset mid-sweep or mid-operation:**
  - In-flight responses are discarded and never emitted.
  - The FSM returns to INIT and the full sweep restarts from address 0 after `rst` returns high.
- **`req_*` during INIT:** ignored; no memory change and no response.
- **Address width:** with `DEPTH` not a power of two (e.g. 24), addresses 24–31 are out of range. The sweep counter stops at `DEPTH-1` and never wraps.

## Test plan
- **Reset and sweep:**
  - Stimulus: WIDTH=16, DEPTH=32, RD_LAT=1; reset for 2 cycles, then release.
  - Required: `req_ready` rises exactly 32 cycles after release; reads of addresses 0–31 all return 0x0000 with `rsp_err` = 0.
- **Masked write:**
  - Stimulus: write 0xFFFF to address 5 with mask 4'b1111, then write 0x1234 to address 5 with mask 4'b0101.
  - Required: a read of address 5 returns 0xF2F4.
- **Back-to-back and latency:**
  - Stimulus: RD_LAT=3; write 0xA5A5 to address 7 at edge A, then read address 7 at edge A+1.
  - Required: the write response pulses at A+3; the read response pulses at A+4 with 0xA5A5.
- **Out of range:**
  - Stimulus: DEPTH=24; write 0xBEEF to address 25, then read address 25.
  - Required: both responses have `rsp_err` = 1 and the read returns 0x0000; a read of address 1 is unaffected.
- **Streaming:**
  - Stimulus: `req_valid` held high; write addresses 0–31 with data equal to the address, then read them back back-to-back.
  - Required: 64 consecutive `rsp_valid` pulses; read data 0..31 in order.
- **Reset mid-operation:**
  - Stimulus: assert `rst` = 0 for 1 cycle with 2 reads in flight (RD_LAT=2), after address 3 was written 0x0F0F.
  - Required: no `rsp_valid` pulse is emitted, the sweep reruns, and address 3 then reads 0x0000.
